// File: rtl/alu_ctrl.sv
// Sequencer for an external 8-bit ALU: owns a 4x8 register file, issues one
// instruction every three cycles and retires the result with status flags.
module alu_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [8:0] instr,
  input  logic [7:0] imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       done,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic       div_zero,
  output logic       halted,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data
);

  // instr_valid/instr_ready: an instruction transfers on the rising edge where
  // both are high; instr and imm are don't-care whenever instr_ready is low.

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] regs [4];
  logic [2:0] op_q;
  logic [1:0] rd_q;
  logic [7:0] imm_q;

  logic [2:0] op;
  logic [1:0] rd;
  logic [1:0] rs1;
  logic [1:0] rs2;

  assign op  = instr[8:6];
  assign rd  = instr[5:4];
  assign rs1 = instr[3:2];
  assign rs2 = instr[1:0];

  assign instr_ready = (state == IDLE);
  assign dbg_data    = regs[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_sel    <= 3'b000;
      op_q       <= OP_NOP;
      rd_q       <= 2'd0;
      imm_q      <= 8'h00;
      done       <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      div_zero   <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q  <= op;
            rd_q  <= rd;
            imm_q <= imm;
            // Only real ALU ops disturb the operand registers.
            if (op <= OP_SHR) begin
              alu_a   <= regs[rs1];
              alu_b   <= regs[rs2];
              alu_sel <= op;
            end else begin
              alu_sel <= 3'b111;
            end
            if (op == OP_HALT) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          state <= DONE;
          done  <= 1'b1;
          case (op_q)
            OP_ADD, OP_SUB, OP_MUL, OP_SHR: begin
              regs[rd_q] <= alu_out;
              zero_flag  <= (alu_out == 8'h00);
              carry_flag <= (op_q == OP_ADD) ? alu_carry : 1'b0;
            end
            OP_DIV: begin
              // A zero divisor leaves the file and flags untouched.
              if (alu_b == 8'h00) begin
                div_zero <= 1'b1;
              end else begin
                regs[rd_q] <= alu_out;
                zero_flag  <= (alu_out == 8'h00);
                carry_flag <= 1'b0;
              end
            end
            OP_LDI: begin
              regs[rd_q] <= imm_q;
              zero_flag  <= (imm_q == 8'h00);
            end
            default: ;
          endcase
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        HALT: state <= HALT;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: external ALU model, cycle-level reference model of the
// controller, per-cycle compare, directed scenarios and random instructions.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [8:0] instr;
  logic [7:0] imm;
  logic [7:0] alu_a, alu_b, alu_out, dbg_data;
  logic [2:0] alu_sel;
  logic       alu_carry, done, carry_flag, zero_flag, div_zero, halted;
  logic [1:0] dbg_addr;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  alu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm(imm), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .done(done), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .div_zero(div_zero), .halted(halted),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done) done_cnt++;

  // External combinational ALU
  always_comb begin
    alu_out   = 8'h00;
    alu_carry = 1'b0;
    case (alu_sel)
      3'd0: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = alu_a * alu_b;
      3'd3: alu_out = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
      3'd4: alu_out = alu_a >> 1;
      default: ;
    endcase
  end

  // Reference model: age counts cycles since acceptance (0 = ready for more).
  logic [7:0] m_regs [4] = '{default: 8'h00};
  logic       m_c = 0, m_z = 0, m_dz = 0, m_halt = 0, m_done = 0;
  logic [7:0] m_a = 0, m_b = 0;
  logic [2:0] m_sel = 0;
  int         age = 0;
  logic [2:0] p_op;
  logic [1:0] p_rd;
  logic [7:0] p_x, p_y, p_imm;

  always @(posedge clk or negedge rst_n) begin : model
    logic [8:0] s9;
    logic [7:0] r;
    bit         wr;
    if (!rst_n) begin
      m_regs = '{default: 8'h00};
      m_c = 0; m_z = 0; m_dz = 0; m_halt = 0; m_done = 0;
      m_a = 0; m_b = 0; m_sel = 0; age = 0;
    end else if (m_halt) begin
      m_done = 0;
    end else if (age == 0) begin
      if (instr_valid) begin
        p_op  = instr[8:6];
        p_rd  = instr[5:4];
        p_x   = m_regs[instr[3:2]];
        p_y   = m_regs[instr[1:0]];
        p_imm = imm;
        if (p_op <= 3'd4) begin
          m_a = p_x; m_b = p_y; m_sel = p_op;
        end else begin
          m_sel = 3'd7;
        end
        if (p_op == 3'd6) m_halt = 1;
        else age = 1;
      end
    end else if (age == 1) begin
      wr = 0;
      r  = 8'h00;
      case (p_op)
        3'd0: begin s9 = {1'b0, p_x} + {1'b0, p_y}; r = s9[7:0]; wr = 1; end
        3'd1: begin r = p_x - p_y; wr = 1; end
        3'd2: begin r = p_x * p_y; wr = 1; end
        3'd3: if (p_y == 0) m_dz = 1; else begin r = p_x / p_y; wr = 1; end
        3'd4: begin r = p_x >> 1; wr = 1; end
        3'd5: begin m_regs[p_rd] = p_imm; m_z = (p_imm == 0); end
        default: ;
      endcase
      if (wr) begin
        m_regs[p_rd] = r;
        m_z = (r == 0);
        m_c = (p_op == 3'd0) ? s9[8] : 1'b0;
      end
      m_done = 1;
      age = 2;
    end else begin
      m_done = 0;
      age = 0;
    end
  end

  // Scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("instr_ready", instr_ready, (!m_halt && age == 0));
    chk("done", done, m_done);
    chk("halted", halted, m_halt);
    chk("carry_flag", carry_flag, m_c);
    chk("zero_flag", zero_flag, m_z);
    chk("div_zero", div_zero, m_dz);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_sel", alu_sel, m_sel);
    chk("dbg_data", dbg_data, m_regs[dbg_addr]);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic [7:0] im, output int acc);
    bit ok = 0;
    instr_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (instr_ready) begin
        instr = {op, rd, rs1, rs2};
        imm   = im;
        ok    = 1;
      end else begin
        instr = 9'($urandom);
        imm   = 8'($urandom);
      end
      dbg_addr = 2'($urandom);
      tick();
    end
    acc = cyc;
    chk("accept_timeout", ok, 1);
  endtask

  task automatic settle();
    instr_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic chk_reg(input string name, input logic [1:0] idx, input logic [7:0] exp);
    dbg_addr = idx;
    #1;
    chk(name, dbg_data, exp);
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", instr_ready, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int a0, a1, a2, a3, d0;
    logic [2:0] op;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; imm = '0; dbg_addr = '0;
    #1 chk_en = 1'b1;
    repeat (2) tick();
    chk("reset_alu_sel", alu_sel, 0);
    chk("reset_halted", halted, 0);
    chk("reset_done", done, 0);
    for (int i = 0; i < 4; i++) chk_reg("reset_reg", 2'(i), 8'h00);
    rst_n = 1'b1;
    tick();

    // LDI r1,7F; LDI r2,81; ADD r3,r1,r2
    d0 = done_cnt;
    send(3'd5, 2'd1, 2'd0, 2'd0, 8'h7F, a0);
    send(3'd5, 2'd2, 2'd0, 2'd0, 8'h81, a0);
    send(3'd0, 2'd3, 2'd1, 2'd2, 8'h00, a0);
    settle();
    chk_reg("add_wrap_r3", 2'd3, 8'h00);
    chk("add_carry", carry_flag, 1);
    chk("add_zero", zero_flag, 1);
    chk("add_done_pulses", done_cnt - d0, 3);

    // r0=5, r1=7; SUB r2,r0,r1; MUL r3,r2,r2
    send(3'd5, 2'd0, 2'd0, 2'd0, 8'h05, a0);
    send(3'd5, 2'd1, 2'd0, 2'd0, 8'h07, a0);
    send(3'd1, 2'd2, 2'd0, 2'd1, 8'h00, a0);
    settle();
    chk_reg("sub_r2", 2'd2, 8'hFE);
    chk("sub_carry", carry_flag, 0);
    chk("sub_zero", zero_flag, 0);
    send(3'd2, 2'd3, 2'd2, 2'd2, 8'h00, a0);
    settle();
    chk_reg("mul_r3", 2'd3, 8'h04);

    // r1=9, r0=0; DIV r2,r1,r0
    send(3'd5, 2'd1, 2'd0, 2'd0, 8'h09, a0);
    send(3'd5, 2'd0, 2'd0, 2'd0, 8'h00, a0);
    settle();
    d0 = done_cnt;
    send(3'd3, 2'd2, 2'd1, 2'd0, 8'h00, a0);
    settle();
    chk_reg("div0_r2_kept", 2'd2, 8'hFE);
    chk("div0_flag", div_zero, 1);
    chk("div0_zero_kept", zero_flag, 1);
    chk("div0_done_once", done_cnt - d0, 1);
    send(3'd7, 2'd0, 2'd0, 2'd0, 8'h00, a0);
    send(3'd0, 2'd3, 2'd1, 2'd1, 8'h00, a0);
    settle();
    chk("div0_sticky", div_zero, 1);
    chk_reg("add_after_div0", 2'd3, 8'h12);

    // Back-to-back stream with instr_valid held high
    send(3'd5, 2'd0, 2'd0, 2'd0, 8'h01, a0);
    send(3'd5, 2'd1, 2'd0, 2'd0, 8'h02, a1);
    send(3'd0, 2'd2, 2'd0, 2'd1, 8'h00, a2);
    send(3'd4, 2'd3, 2'd2, 2'd0, 8'h00, a3);
    settle();
    chk("stream_gap1", a1 - a0, 3);
    chk("stream_gap2", a2 - a1, 3);
    chk("stream_gap3", a3 - a2, 3);
    chk_reg("stream_shr_r3", 2'd3, 8'h01);

    // Reset pulsed during ISSUE of LDI r0,AA
    d0 = done_cnt;
    send(3'd5, 2'd0, 2'd0, 2'd0, 8'hAA, a0);
    instr_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk_reg("abort_r0", 2'd0, 8'h00);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_ready", instr_ready, 1);

    // HALT then more offers
    send(3'd5, 2'd3, 2'd0, 2'd0, 8'h5A, a0);
    send(3'd6, 2'd0, 2'd0, 2'd0, 8'h00, a0);
    instr = {3'd5, 2'd3, 2'd0, 2'd0};
    imm = 8'h33;
    repeat (8) tick();
    chk("halt_ready", instr_ready, 0);
    chk("halt_flag", halted, 1);
    chk_reg("halt_r3_kept", 2'd3, 8'h5A);
    do_reset();
    send(3'd5, 2'd2, 2'd0, 2'd0, 8'h3C, a0);
    settle();
    chk_reg("post_halt_ldi", 2'd2, 8'h3C);

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd6 && $urandom_range(0, 9) != 0) op = 3'd7;
      if ($urandom_range(0, 1) == 0) begin
        instr_valid = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          instr = 9'($urandom); imm = 8'($urandom); dbg_addr = 2'($urandom);
          tick();
        end
      end
      send(op, 2'($urandom), 2'($urandom), 2'($urandom),
           ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), a0);
      if (op == 3'd6) begin
        repeat (4) begin
          instr = 9'($urandom); dbg_addr = 2'($urandom);
          tick();
        end
        do_reset();
      end
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock), rst_n input 1 (reset, asserted low).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- instr_valid  input   1  instruction offered
- instr_ready  output  1  controller can accept an instruction
- instr        input   9  op[8:6], rd[5:4], rs1[3:2], rs2[1:0]
- imm          input   8  immediate for LDI, sampled with instr
- alu_a        output  8  operand A to the external ALU, registered
- alu_b        output  8  operand B to the external ALU, registered
- alu_sel      output  3  ALU select, registered
- alu_out      input   8  ALU result, combinational from alu_a/alu_b/alu_sel
- alu_carry    input   1  ALU carry, meaningful for ADD only
- done         output  1  one-cycle pulse, instruction retired
- carry_flag   output  1  status carry
- zero_flag    output  1  status zero
- div_zero     output  1  sticky divide-by-zero error
- halted       output  1  controller halted
- dbg_addr     input   2  debug register select
- dbg_data     output  8  combinational read of regs[dbg_addr]

Function
REQ-003 Register file SHALL be 4 x 8-bit (r0..r3), all writable; rs1 == rs2 and rd == rs1 or rd == rs2 SHALL be legal.
REQ-004 Opcodes SHALL be:
- 000 ADD, 001 SUB, 010 MUL (low 8 bits), 011 DIV (unsigned quotient), 100 SHR (rs1 >> 1; rs2 ignored): ALU ops, alu_sel = op
- 101 LDI: rd <= imm
- 110 HALT
- 111 NOP
REQ-005 The FSM SHALL have states IDLE, ISSUE, DONE and HALT.
REQ-006 IDLE: instr_ready = 1; an instruction is accepted on a rising edge where instr_valid && instr_ready; acceptance moves the state to ISSUE, or to HALT when op = 110.
REQ-007 At the acceptance edge the block SHALL load alu_a <= regs[rs1], alu_b <= regs[rs2] and alu_sel <= op[2:0]; for LDI, HALT and NOP it SHALL load alu_sel <= 3'b111 and leave alu_a/alu_b unchanged.
REQ-008 alu_a, alu_b and alu_sel SHALL hold their values in all states other than the acceptance edge.
REQ-009 ISSUE lasts one cycle. On the ISSUE->DONE edge:
- ALU op: regs[rd] <= alu_out; zero_flag <= (alu_out == 0); carry_flag <= alu_carry for ADD, 0 for other ALU ops
- LDI: regs[rd] <= imm; zero_flag <= (imm == 0); carry_flag unchanged
- NOP: no register write, no flag change
REQ-010 DIV with alu_b == 0 SHALL suppress the write and leave carry_flag and zero_flag unchanged; div_zero SHALL set to 1 at the ISSUE->DONE edge and stay 1 until reset.
REQ-011 DONE: done = 1 and instr_ready = 0 for exactly one cycle, then the state returns to IDLE.
REQ-012 Throughput SHALL be one instruction per 3 cycles: acceptance at edge T0 gives the write at T1, done high during T1..T2, and instr_ready high again from T2.
REQ-013 HALT: instr_ready = 0 and halted = 1 until reset; no done pulse, no register or flag change.
REQ-014 instr_ready SHALL be 1 only in IDLE; instr and imm SHALL be ignored whenever instr_ready = 0.
REQ-015 dbg_data SHALL be combinational and show the written value in the cycle after the write edge.
REQ-016 All arithmetic SHALL be unsigned 8-bit and wrap modulo 256.

Reset
REQ-017 While rst_n = 0, asynchronously: state = IDLE; regs, alu_a, alu_b = 8'h00; alu_sel = 3'b000; done, carry_flag, zero_flag, div_zero, halted = 0.
REQ-018 A reset asserted during ISSUE SHALL abort the instruction, with no register write and no done pulse.
REQ-019 instr_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-020 LDI r1,0x7F; LDI r2,0x81; ADD r3,r1,r2 -> r3 = 0x00, carry_flag = 1, zero_flag = 1, three done pulses.
REQ-021 r0 = 0x05, r1 = 0x07; SUB r2,r0,r1 -> r2 = 0xFE, carry_flag = 0, zero_flag = 0; then MUL r3,r2,r2 -> r3 = 0x04.
REQ-022 r1 = 0x09, r0 = 0x00; DIV r2,r1,r0 -> r2 unchanged, div_zero = 1 and still 1 after later ops; done pulses once.
REQ-023 instr_valid held high with a 4-instruction stream -> acceptances exactly 3 cycles apart; instr_ready low in ISSUE and DONE.
REQ-024 HALT then more valid instructions -> instr_ready stays 0, halted = 1, regs unchanged; after reset, an LDI is accepted normally.
REQ-025 rst_n pulsed low during ISSUE of LDI r0,0xAA -> r0 = 0x00, no done pulse, IDLE after release.
